// File: rtl/pwm_compare_unit_pkg.sv
// pwm_compare_unit_pkg: shared state encoding and default sizes for the PWM compare unit.
package pwm_cmp_pkg;
  localparam int WIDTH_D = 4;
  localparam int PCNT_W_D = 8;
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  function automatic int max_of(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/pwm_compare_unit_if.sv
// pwm_compare_unit_if: duty-value valid/ready handshake between producer and compare unit.
interface pwm_compare_unit_if #(parameter int WIDTH = 4);
  logic             duty_valid;
  logic [WIDTH-1:0] duty_data;
  logic             duty_ready;
  modport master(output duty_valid, duty_data, input duty_ready);
  modport slave(input duty_valid, duty_data, output duty_ready);
endinterface

// File: rtl/pwm_compare_unit_wrap_detect.sv
// pwm_wrap_detect: flags MAX->0 and 0->MAX transitions of the sampled count once history is primed.
module pwm_wrap_detect
  import pwm_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_D
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] count,
  output logic             wrap_up,
  output logic             wrap_dn
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_of(WIDTH));
  logic [WIDTH-1:0] count_q;
  logic             hist_valid;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      count_q    <= '0;
      hist_valid <= 1'b0;
    end else begin
      count_q    <= count;
      hist_valid <= 1'b1;
    end
  assign wrap_up = hist_valid && count_q == MAX && count == '0;
  assign wrap_dn = hist_valid && count_q == '0 && count == MAX;
endmodule

// File: rtl/pwm_compare_unit.sv
// pwm_compare_unit: PWM from count vs double-buffered duty, period boundary at count wrap.
// Optional sticky wrap interrupt (irq/irq_clr) when PWM_IRQ_EN is defined.
module pwm_compare_unit
  import pwm_cmp_pkg::*;
#(
  parameter int WIDTH  = WIDTH_D,
  parameter int PCNT_W = PCNT_W_D
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [WIDTH-1:0]  count,
  pwm_compare_unit_if.slave duty,
  output logic              pwm_out,
  output logic              wrap_pulse,
  output logic              wrap_dir,
  output logic [PCNT_W-1:0] period_cnt,
  output logic [WIDTH-1:0]  active_duty
`ifdef PWM_IRQ_EN
  ,
  input  logic              irq_clr,
  output logic              irq
`endif
);
  state_t              state, state_d;
  logic                wrap_up, wrap_dn, wrap, wrap_ev, pending, accept, pwm_d;
  logic [WIDTH-1:0]    shadow;
  logic [PCNT_W-1:0]   pcnt_d;
  pwm_wrap_detect #(.WIDTH(WIDTH)) u_wrap (
    .clk    (clk),
    .reset_n(reset_n),
    .count  (count),
    .wrap_up(wrap_up),
    .wrap_dn(wrap_dn)
  );
  assign wrap            = wrap_up | wrap_dn;
  assign wrap_ev         = wrap && state != IDLE;
  assign accept          = duty.duty_valid && !pending;
  assign duty.duty_ready = !pending;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  // Disable wins over a coincident wrap; ARM holds until a full period begins.
  always_comb
    if (!enable)                  state_d = IDLE;
    else if (state == IDLE)       state_d = ARM;
    else if (state == ARM && !wrap) state_d = ARM;
    else                          state_d = RUN;
  always_comb begin
    pwm_d  = state == RUN && enable && count < active_duty;
    pcnt_d = !enable ? period_cnt :
             state == IDLE ? '0 :
             !wrap ? period_cnt :
             state == ARM ? PCNT_W'(1) : period_cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pwm_out     <= 1'b0;
      wrap_pulse  <= 1'b0;
      wrap_dir    <= 1'b0;
      period_cnt  <= '0;
      active_duty <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
    end else begin
      pwm_out    <= pwm_d;
      wrap_pulse <= wrap_ev;
      wrap_dir   <= wrap_ev && wrap_up;
      period_cnt <= pcnt_d;
      if (wrap_ev && pending) begin
        active_duty <= shadow;
        pending     <= 1'b0;
      end
      if (accept) begin
        shadow  <= duty.duty_data;
        pending <= 1'b1;
      end
    end
`ifdef PWM_IRQ_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) irq <= 1'b0;
    else          irq <= wrap_ev | (irq & !irq_clr);
`endif
endmodule
